// File: rtl/serv_ibus_prefetch.sv
// rtl/serv_ibus_prefetch.sv - ibus to Wishbone bridge with one-entry next-word prefetch buffer
//
// Purpose: serves core instruction fetches from Wishbone memory. After each
// demand fetch the next sequential word is fetched into a single-entry buffer
// so that a following sequential fetch is acknowledged without a memory access.
//
// Ports:
//   clk, i_rst_n            clock, asynchronous active-low reset
//   i_ibus_adr, i_ibus_cyc  core fetch address/request (held until o_ibus_ack)
//   o_ibus_rdt, o_ibus_ack  instruction word and single-cycle acknowledge
//   i_flush                 invalidate the prefetch buffer
//   o_wb_adr, o_wb_cyc      Wishbone address (word aligned) and cycle/strobe
//   i_wb_rdt, i_wb_ack      Wishbone read data and acknowledge
//   o_hit                   pulses with o_ibus_ack when served from the buffer

module serv_ibus_prefetch #(
  parameter logic PREFETCH = 1'b1
) (
  input  logic        clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_ibus_adr,
  input  logic        i_ibus_cyc,
  output logic [31:0] o_ibus_rdt,
  output logic        o_ibus_ack,
  input  logic        i_flush,
  output logic [31:0] o_wb_adr,
  output logic        o_wb_cyc,
  input  logic [31:0] i_wb_rdt,
  input  logic        i_wb_ack,
  output logic        o_hit
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DEMAND,
    S_PREFETCH
  } state_t;

  state_t      state;
  logic [29:0] wb_word;    // word address of the current/last Wishbone cycle
  logic        buf_valid;
  logic        discard;    // flush seen while a prefetch was in flight
  logic [29:0] buf_tag;
  logic [31:0] buf_data;

  logic        req;
  logic        buf_hit;
  logic        unused_adr_lsb;

  assign o_wb_adr       = {wb_word, 2'b00};
  assign unused_adr_lsb = ^i_ibus_adr[1:0];

  // The ack cycle itself is not a new request even though cyc is still held.
  assign req     = i_ibus_cyc & ~o_ibus_ack;
  // A flush in the same cycle as a would-be hit turns it into a miss.
  assign buf_hit = req & buf_valid & ~i_flush & (buf_tag == i_ibus_adr[31:2]);

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= S_IDLE;
      wb_word    <= 30'd0;
      o_wb_cyc   <= 1'b0;
      o_ibus_ack <= 1'b0;
      o_ibus_rdt <= 32'd0;
      o_hit      <= 1'b0;
      buf_valid  <= 1'b0;
      discard    <= 1'b0;
      buf_tag    <= 30'd0;
      buf_data   <= 32'd0;
    end else begin
      o_ibus_ack <= 1'b0;
      o_hit      <= 1'b0;
      if (i_flush) begin
        buf_valid <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (req) begin
            o_wb_cyc <= 1'b1;
            if (buf_hit) begin
              o_ibus_ack <= 1'b1;
              o_hit      <= 1'b1;
              o_ibus_rdt <= buf_data;
              buf_valid  <= 1'b0;
              wb_word    <= i_ibus_adr[31:2] + 30'd1;  // wraps naturally
              state      <= S_PREFETCH;
            end else begin
              buf_valid  <= 1'b0;
              wb_word    <= i_ibus_adr[31:2];
              state      <= S_DEMAND;
            end
          end
        end

        S_DEMAND: begin
          if (i_wb_ack) begin
            o_ibus_rdt <= i_wb_rdt;
            o_ibus_ack <= 1'b1;
            if (PREFETCH) begin
              // Keep the bus owned and move straight on to the next word.
              wb_word <= wb_word + 30'd1;
              state   <= S_PREFETCH;
            end else begin
              o_wb_cyc <= 1'b0;
              state    <= S_IDLE;
            end
          end
        end

        S_PREFETCH: begin
          if (i_flush) begin
            discard <= 1'b1;
          end
          if (i_wb_ack) begin
            buf_data  <= i_wb_rdt;
            buf_tag   <= wb_word;
            buf_valid <= ~discard & ~i_flush;
            discard   <= 1'b0;
            o_wb_cyc  <= 1'b0;
            state     <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serv_ibus_prefetch.sv
// tb/tb_serv_ibus_prefetch.sv - randomized self-checking bench for serv_ibus_prefetch

module tb_serv_ibus_prefetch;

  logic        clk;
  logic        rst_n;
  logic [31:0] i_ibus_adr;
  logic        i_ibus_cyc;
  logic [31:0] o_ibus_rdt;
  logic        o_ibus_ack;
  logic        i_flush;
  logic [31:0] o_wb_adr;
  logic        o_wb_cyc;
  logic [31:0] i_wb_rdt;
  logic        i_wb_ack;
  logic        o_hit;

  int total = 0;
  int bad   = 0;

  serv_ibus_prefetch #(.PREFETCH(1'b1)) dut (
    .clk        (clk),
    .i_rst_n    (rst_n),
    .i_ibus_adr (i_ibus_adr),
    .i_ibus_cyc (i_ibus_cyc),
    .o_ibus_rdt (o_ibus_rdt),
    .o_ibus_ack (o_ibus_ack),
    .i_flush    (i_flush),
    .o_wb_adr   (o_wb_adr),
    .o_wb_cyc   (o_wb_cyc),
    .i_wb_rdt   (i_wb_rdt),
    .i_wb_ack   (i_wb_ack),
    .o_hit      (o_hit)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory contents: fixed pseudo-random function of address, with overrides.
  logic [31:0] mem_ovr [logic [31:0]];

  function automatic logic [31:0] memval(input logic [31:0] a);
    if (mem_ovr.exists(a)) return mem_ovr[a];
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  // Wishbone memory responder with configurable wait states.
  int          min_delay = 0;
  int          max_extra = 2;
  bit          stall     = 1'b0;
  int          cnt       = -1;
  logic [31:0] wb_log [$];

  initial begin
    i_wb_ack = 1'b0;
    i_wb_rdt = 32'd0;
    forever begin
      @(negedge clk);
      if (!rst_n || !o_wb_cyc || stall) begin
        i_wb_ack = 1'b0;
        cnt      = -1;
      end else begin
        if (cnt < 0) cnt = min_delay + $urandom_range(0, max_extra);
        if (cnt > 0) begin
          cnt--;
          i_wb_ack = 1'b0;
        end else begin
          i_wb_ack = 1'b1;
          i_wb_rdt = memval(o_wb_adr);
          wb_log.push_back(o_wb_adr);
          cnt = -1;
        end
      end
    end
  end

  // Reference model: one-entry buffer state and the expected Wishbone address trace.
  bit          mvalid = 1'b0;
  logic [29:0] mtag   = 30'd0;
  logic [31:0] exp_log [$];
  bit          idle_now = 1'b1;

  task automatic fetch(input logic [31:0] adr, input logic flush_now);
    logic        exp_hit;
    logic [31:0] exp_data;
    logic [29:0] w;
    int          n;
    w        = adr[31:2];
    exp_hit  = mvalid && !flush_now && (mtag == w);
    exp_data = memval({w, 2'b00});
    if (!exp_hit) exp_log.push_back({w, 2'b00});
    exp_log.push_back({w + 30'd1, 2'b00});
    mvalid = 1'b1;
    mtag   = w + 30'd1;

    i_ibus_adr = adr;
    i_ibus_cyc = 1'b1;
    i_flush    = flush_now;
    n = 0;
    do begin
      @(negedge clk);
      i_flush = 1'b0;
      n++;
    end while (!o_ibus_ack && n < 200);

    total++;
    if (o_ibus_ack !== 1'b1) begin
      bad++;
      $display("FAIL ack_timeout adr=%h got_ack=%b want=1", adr, o_ibus_ack);
    end
    total++;
    if (o_ibus_rdt !== exp_data) begin
      bad++;
      $display("FAIL rdt adr=%h got=%h want=%h", adr, o_ibus_rdt, exp_data);
    end
    total++;
    if (o_hit !== exp_hit) begin
      bad++;
      $display("FAIL hit adr=%h got=%b want=%b", adr, o_hit, exp_hit);
    end
    if (idle_now && exp_hit) begin
      total++;
      if (n != 1) begin
        bad++;
        $display("FAIL hit_latency adr=%h got=%0d want=1", adr, n);
      end
    end
    i_ibus_cyc = 1'b0;
    idle_now   = 1'b0;
  endtask

  task automatic check_log();
    int n;
    n = 0;
    while (o_wb_cyc !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (o_wb_cyc !== 1'b0) begin
      bad++;
      $display("FAIL wb_idle_timeout got_cyc=%b want=0", o_wb_cyc);
    end
    total++;
    if (wb_log.size() != exp_log.size()) begin
      bad++;
      $display("FAIL wb_log_len got=%0d want=%0d", wb_log.size(), exp_log.size());
    end else begin
      foreach (exp_log[i]) begin
        total++;
        if (wb_log[i] !== exp_log[i]) begin
          bad++;
          $display("FAIL wb_adr idx=%0d got=%h want=%h", i, wb_log[i], exp_log[i]);
        end
      end
    end
    wb_log.delete();
    exp_log.delete();
    idle_now = 1'b1;
  endtask

  task automatic pulse_flush();
    @(negedge clk);
    i_flush = 1'b1;
    @(negedge clk);
    i_flush = 1'b0;
    mvalid  = 1'b0;
  endtask

  task automatic test_reset();
    total++;
    if ({o_ibus_ack, o_wb_cyc, o_hit, o_wb_adr, o_ibus_rdt} !== 67'd0) begin
      bad++;
      $display("FAIL reset_outputs got ack=%b cyc=%b hit=%b adr=%h rdt=%h want all 0",
               o_ibus_ack, o_wb_cyc, o_hit, o_wb_adr, o_ibus_rdt);
    end
  endtask

  task automatic test_cold_fetch();
    int n;
    min_delay = 2;
    max_extra = 0;
    mem_ovr[32'h100] = 32'h00500093;
    mem_ovr[32'h104] = 32'h00108113;
    i_ibus_adr = 32'h100;
    i_ibus_cyc = 1'b1;
    @(negedge clk);
    total++;
    if (o_wb_cyc !== 1'b1 || o_wb_adr !== 32'h100 || o_ibus_ack !== 1'b0) begin
      bad++;
      $display("FAIL cold_wb_start got cyc=%b adr=%h ack=%b want 1 00000100 0",
               o_wb_cyc, o_wb_adr, o_ibus_ack);
    end
    n = 1;
    while (!o_ibus_ack && n < 50) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n != 4 || o_ibus_rdt !== 32'h00500093 || o_hit !== 1'b0) begin
      bad++;
      $display("FAIL cold_ack got cycles=%0d rdt=%h hit=%b want 4 00500093 0", n, o_ibus_rdt, o_hit);
    end
    total++;
    if (o_wb_cyc !== 1'b1 || o_wb_adr !== 32'h104) begin
      bad++;
      $display("FAIL cold_prefetch got cyc=%b adr=%h want 1 00000104", o_wb_cyc, o_wb_adr);
    end
    i_ibus_cyc = 1'b0;
    exp_log.push_back(32'h100);
    exp_log.push_back(32'h104);
    mvalid = 1'b1;
    mtag   = 30'h41;
    idle_now = 1'b0;
    check_log();
    min_delay = 0;
    max_extra = 2;
  endtask

  task automatic test_seq_hit();
    fetch(32'h104, 1'b0);
    check_log();
  endtask

  task automatic test_branch_miss();
    fetch(32'h200, 1'b0);
    check_log();
  endtask

  task automatic test_flush_prefetch();
    min_delay = 3;
    fetch(32'h104, 1'b0);
    total++;
    if (o_wb_cyc !== 1'b1 || o_wb_adr !== 32'h108) begin
      bad++;
      $display("FAIL flush_pf_pending got cyc=%b adr=%h want 1 00000108", o_wb_cyc, o_wb_adr);
    end
    i_flush = 1'b1;
    @(negedge clk);
    i_flush = 1'b0;
    mvalid  = 1'b0;
    min_delay = 0;
    check_log();
    fetch(32'h108, 1'b0);
    check_log();
    fetch(32'h10C, 1'b1);
    check_log();
  endtask

  task automatic test_wrap();
    fetch(32'hFFFFFFFC, 1'b0);
    check_log();
    fetch(32'h0, 1'b0);
    check_log();
  endtask

  task automatic test_back_to_back();
    fetch(32'h400, 1'b0);
    fetch(32'h404, 1'b0);
    fetch(32'h409, 1'b0);
    check_log();
  endtask

  task automatic test_reset_mid_demand();
    stall = 1'b1;
    i_ibus_adr = 32'h300;
    i_ibus_cyc = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (o_wb_cyc !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid_start got cyc=%b want 1", o_wb_cyc);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (o_wb_cyc !== 1'b0 || o_ibus_ack !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_drop got cyc=%b ack=%b want 0 0", o_wb_cyc, o_ibus_ack);
    end
    i_ibus_cyc = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    stall = 1'b0;
    mvalid = 1'b0;
    wb_log.delete();
    exp_log.delete();
    @(negedge clk);
    total++;
    if (o_ibus_ack !== 1'b0 || o_wb_cyc !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_after got ack=%b cyc=%b want 0 0", o_ibus_ack, o_wb_cyc);
    end
    idle_now = 1'b1;
    fetch(32'h100, 1'b0);
    check_log();
  endtask

  task automatic test_random();
    logic [31:0] adr;
    adr = 32'h1000;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) < 6) adr = adr + 32'd4;
      else adr = $urandom;
      if ($urandom_range(0, 4) == 0) pulse_flush();
      fetch(adr, ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 3) != 0) check_log();
    end
    check_log();
  endtask

  initial begin
    rst_n      = 1'b0;
    i_ibus_adr = 32'd0;
    i_ibus_cyc = 1'b0;
    i_flush    = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_cold_fetch();
    test_seq_hit();
    test_branch_miss();
    test_flush_prefetch();
    test_wrap();
    test_back_to_back();
    test_reset_mid_demand();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serv_ibus_prefetch.md
Name: serv_ibus_prefetch

Overview:
Instruction-bus bridge between the core's ibus initiator and the external Wishbone instruction memory. It supplies the instruction words that the decode stage latches. After every demand fetch it speculatively fetches the next sequential word (PC+4) into a one-entry buffer. A sequential request that hits the buffer is acknowledged without a memory access.

Parameters:
PREFETCH, 1, 1 enables next-word prefetch; 0 makes the block a registered pass-through (DEMAND only, never PREFETCH)

Ports:
clk  input  1  clock
i_rst_n  input  1  asynchronous active-low reset
i_ibus_adr  input  32  core fetch address; bits [1:0] ignored
i_ibus_cyc  input  1  core fetch request; held with i_ibus_adr until o_ibus_ack
o_ibus_rdt  output  32  instruction word to core/decode
o_ibus_ack  output  1  single-cycle ack; o_ibus_rdt valid in the same cycle
i_flush  input  1  invalidate buffer (fence.i, trap redirect)
o_wb_adr  output  32  Wishbone address; [1:0] always 0
o_wb_cyc  output  1  Wishbone cycle/strobe
i_wb_rdt  input  32  Wishbone read data
i_wb_ack  input  1  Wishbone ack
o_hit  output  1  one-cycle pulse, coincident with o_ibus_ack, when the ack was served from the buffer

Behaviour:
- Reset (async assert, sync release) values:
  - o_ibus_ack=0, o_wb_cyc=0, o_hit=0
  - o_wb_adr=0, o_ibus_rdt=0
  - buffer valid=0, discard flag=0, state=IDLE
- Reset mid-operation: o_wb_cyc drops immediately and the Wishbone cycle is abandoned.
- A request is a cycle with i_ibus_cyc=1 and o_ibus_ack=0. Compare {adr[31:2]} only.
- IDLE:
  - Request, buffer valid, tag==adr (hit): next cycle o_ibus_ack=1, o_hit=1, o_ibus_rdt=buffer data. Buffer is consumed (valid=0). Go to PREFETCH with adr+4.
  - Request, miss: next cycle o_wb_cyc=1, o_wb_adr=adr&~3. Go to DEMAND. Buffer is invalidated.
  - No request: stay in IDLE.
- DEMAND: hold o_wb_cyc and o_wb_adr until i_wb_ack. On ack:
  - Register i_wb_rdt into o_ibus_rdt and pulse o_ibus_ack the next cycle.
  - In that same cycle, go to PREFETCH (adr+4, o_wb_cyc=1) if PREFETCH=1, else go to IDLE with o_wb_cyc=0.
- PREFETCH: o_wb_cyc=1, o_wb_adr=tag. On i_wb_ack: buffer data=i_wb_rdt; valid=!discard; clear discard; go to IDLE. A core request arriving during PREFETCH waits; it is evaluated in IDLE the cycle after the prefetch ack.
- Wishbone cycles are never aborted except by reset. o_wb_cyc deasserts the cycle after i_wb_ack.
- Latency: hit = 1 cycle from request to o_ibus_ack. Miss = 1 cycle to o_wb_cyc, plus memory wait, plus 1 cycle after i_wb_ack.
- Address arithmetic wraps modulo 2^32: 0xFFFFFFFC+4 = 0x00000000.
- i_flush:
  - Clears buffer valid in the same cycle.
  - If asserted in PREFETCH, sets discard so the in-flight word is not marked valid.
  - If coincident with a hit decision in IDLE, flush wins and the request is treated as a miss.
  - Flush has no effect on DEMAND data.
- o_ibus_rdt holds its last value when o_ibus_ack=0.
- i_wb_ack while o_wb_cyc=0 is ignored.

Test Plan:
1. Cold fetch: request 0x00000100, memory acks after 2 cycles with 0x00500093 -> o_wb_adr=0x100; o_ibus_ack one cycle after the wb ack with rdt=0x00500093, o_hit=0; then o_wb_cyc=1 at 0x104.
2. Sequential hit: after scenario 1, the prefetch of 0x104 returns 0x00108113; core requests 0x104 -> o_ibus_ack 1 cycle later, rdt=0x00108113, o_hit=1, no wb cycle for 0x104; next wb cycle is at 0x108.
3. Branch miss: buffer holds 0x108; core requests 0x200 -> o_hit=0, o_wb_adr=0x200, buffer invalid afterwards.
4. Flush during prefetch: i_flush while PREFETCH 0x108 is outstanding, then request 0x108 -> prefetched word discarded, new DEMAND wb cycle at 0x108.
5. Wrap: demand fetch at 0xFFFFFFFC -> prefetch o_wb_adr=0x00000000; request 0 hits.
6. Reset mid-DEMAND: drop i_rst_n while o_wb_cyc=1 -> o_wb_cyc=0 immediately, no o_ibus_ack; after release, request 0x100 performs a fresh demand fetch.
